// File: rtl/hicore_lsu_dtcm_align.sv
// LSU-to-DTCM alignment shim: word-aligns ICB commands, builds byte masks and replicated store data,
// and formats read responses in command order using a small in-order tracking FIFO.
module hicore_lsu_dtcm_align #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int OUTSTND = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic          lsu_cmd_read,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic [1:0]    lsu_cmd_size,
  input  logic          lsu_cmd_usign,
  input  logic [DW-1:0] lsu_cmd_wdata,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic          lsu_rsp_err,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          mem_icb_cmd_valid,
  input  logic          mem_icb_cmd_ready,
  output logic          mem_icb_cmd_read,
  output logic [AW-1:0] mem_icb_cmd_addr,
  output logic [DW-1:0] mem_icb_cmd_wdata,
  output logic [3:0]    mem_icb_cmd_wmask,
  input  logic          mem_icb_rsp_valid,
  output logic          mem_icb_rsp_ready,
  input  logic          mem_icb_rsp_err,
  input  logic [DW-1:0] mem_icb_rsp_rdata
);

  localparam int PW = (OUTSTND > 1) ? $clog2(OUTSTND) : 1;
  localparam int CW = $clog2(OUTSTND + 1);

  typedef struct packed {
    logic       mis;
    logic       read;
    logic [1:0] size;
    logic       usign;
    logic [1:0] ofs;
  } ent_t;

  ent_t          fifo [OUTSTND];
  ent_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          mis, full, empty, push, pop;
  logic [DW-1:0] shifted, ext;

  assign mis = (lsu_cmd_size == 2'd3)
             | ((lsu_cmd_size == 2'd1) & lsu_cmd_addr[0])
             | ((lsu_cmd_size == 2'd2) & (lsu_cmd_addr[1:0] != 2'b00));

  assign full  = (count == CW'(OUTSTND));
  assign empty = (count == '0);

  // Ready deliberately ignores a same-cycle pop so there is no rsp_ready -> cmd_ready path.
  assign mem_icb_cmd_valid = ~rst & lsu_cmd_valid & ~full & ~mis;
  assign lsu_cmd_ready     = ~rst & ~full & (mis | mem_icb_cmd_ready);
  assign mem_icb_cmd_read  = lsu_cmd_read;
  assign mem_icb_cmd_addr  = {lsu_cmd_addr[AW-1:2], 2'b00};

  always_comb begin
    case (lsu_cmd_size)
      2'd0:    mem_icb_cmd_wdata = {4{lsu_cmd_wdata[7:0]}};
      2'd1:    mem_icb_cmd_wdata = {2{lsu_cmd_wdata[15:0]}};
      default: mem_icb_cmd_wdata = lsu_cmd_wdata;
    endcase
  end

  always_comb begin
    mem_icb_cmd_wmask = 4'hF;
    if (!lsu_cmd_read) begin
      case (lsu_cmd_size)
        2'd0:    mem_icb_cmd_wmask = 4'b0001 << lsu_cmd_addr[1:0];
        2'd1:    mem_icb_cmd_wmask = 4'b0011 << {lsu_cmd_addr[1], 1'b0};
        default: mem_icb_cmd_wmask = 4'hF;
      endcase
    end
  end

  assign push = lsu_cmd_valid & lsu_cmd_ready;
  assign pop  = lsu_rsp_valid & lsu_rsp_ready;
  assign head = fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= '{mis: mis, read: lsu_cmd_read, size: lsu_cmd_size,
                        usign: lsu_cmd_usign, ofs: lsu_cmd_addr[1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(OUTSTND - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(OUTSTND - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign shifted = mem_icb_rsp_rdata >> {head.ofs, 3'b000};

  always_comb begin
    case (head.size)
      2'd0:    ext = head.usign ? {{(DW-8){1'b0}}, shifted[7:0]}
                                : {{(DW-8){shifted[7]}}, shifted[7:0]};
      2'd1:    ext = head.usign ? {{(DW-16){1'b0}}, shifted[15:0]}
                                : {{(DW-16){shifted[15]}}, shifted[15:0]};
      default: ext = mem_icb_rsp_rdata;
    endcase
  end

  // Misaligned entries answer locally; the DTCM never saw them, so its response channel is untouched.
  always_comb begin
    lsu_rsp_valid     = 1'b0;
    lsu_rsp_err       = 1'b0;
    lsu_rsp_rdata     = '0;
    mem_icb_rsp_ready = 1'b0;
    if (!empty) begin
      if (head.mis) begin
        lsu_rsp_valid = 1'b1;
        lsu_rsp_err   = 1'b1;
      end else begin
        lsu_rsp_valid     = mem_icb_rsp_valid;
        lsu_rsp_err       = mem_icb_rsp_err;
        mem_icb_rsp_ready = lsu_rsp_ready;
        if (head.read && !mem_icb_rsp_err)
          lsu_rsp_rdata = ext;
      end
    end
  end

endmodule

// File: tb/tb_hicore_lsu_dtcm_align.sv
// Directed bench for hicore_lsu_dtcm_align with a simple DTCM model and an in-order response scoreboard.
module tb_hicore_lsu_dtcm_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read, lsu_cmd_usign;
  logic [31:0] lsu_cmd_addr, lsu_cmd_wdata;
  logic [1:0]  lsu_cmd_size;
  logic        lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_icb_cmd_valid, mem_icb_cmd_ready, mem_icb_cmd_read;
  logic [31:0] mem_icb_cmd_addr, mem_icb_cmd_wdata;
  logic [3:0]  mem_icb_cmd_wmask;
  logic        mem_icb_rsp_valid, mem_icb_rsp_ready, mem_icb_rsp_err;
  logic [31:0] mem_icb_rsp_rdata;

  int checks = 0;
  int errors = 0;
  int rsp_mode = 0;
  int outst = 0;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t expq[$];

  logic [31:0] mem [256];
  logic [31:0] rq[$];

  hicore_lsu_dtcm_align #(.AW(32), .DW(32), .OUTSTND(2)) dut (
    .clk(clk), .rst(rst),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_size(lsu_cmd_size), .lsu_cmd_usign(lsu_cmd_usign),
    .lsu_cmd_wdata(lsu_cmd_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_err(lsu_rsp_err),
    .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_icb_cmd_valid(mem_icb_cmd_valid), .mem_icb_cmd_ready(mem_icb_cmd_ready),
    .mem_icb_cmd_read(mem_icb_cmd_read), .mem_icb_cmd_addr(mem_icb_cmd_addr),
    .mem_icb_cmd_wdata(mem_icb_cmd_wdata), .mem_icb_cmd_wmask(mem_icb_cmd_wmask),
    .mem_icb_rsp_valid(mem_icb_rsp_valid), .mem_icb_rsp_ready(mem_icb_rsp_ready),
    .mem_icb_rsp_err(mem_icb_rsp_err), .mem_icb_rsp_rdata(mem_icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // DTCM model: executes at command handshake, answers one cycle later, holds data until accepted.
  initial begin
    logic        cf, rf, cr;
    logic [7:0]  ci;
    logic [31:0] cw;
    logic [3:0]  cm;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h80] = 32'h8001_7F80;
    mem_icb_rsp_valid = 1'b0;
    mem_icb_rsp_err   = 1'b0;
    mem_icb_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cf = mem_icb_cmd_valid & mem_icb_cmd_ready;
      rf = mem_icb_rsp_valid & mem_icb_rsp_ready;
      cr = mem_icb_cmd_read;
      ci = mem_icb_cmd_addr[9:2];
      cw = mem_icb_cmd_wdata;
      cm = mem_icb_cmd_wmask;
      @(posedge clk);
      #1;
      if (rst) rq.delete();
      else begin
        if (rf) void'(rq.pop_front());
        if (cf) begin
          if (cr) rq.push_back(mem[ci]);
          else begin
            for (int b = 0; b < 4; b++)
              if (cm[b]) mem[ci][8*b +: 8] = cw[8*b +: 8];
            rq.push_back(32'h0);
          end
        end
      end
      mem_icb_rsp_valid = (rq.size() != 0);
      mem_icb_rsp_rdata = (rq.size() != 0) ? rq[0] : 32'h0;
    end
  end

  initial begin
    lsu_rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        1:       lsu_rsp_ready = 1'b1;
        2:       lsu_rsp_ready = ~lsu_rsp_ready;
        default: lsu_rsp_ready = 1'b0;
      endcase
    end
  end

  // Response scoreboard, sampled on the falling edge ahead of the handshake edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) outst = 0;
      else begin
        if (mem_icb_rsp_valid)
          assert (outst != 0) else $error("mem rsp valid with no outstanding request");
        if (lsu_cmd_valid & lsu_cmd_ready) outst++;
        if (lsu_rsp_valid & lsu_rsp_ready) begin
          outst--;
          if (expq.size() == 0) chk("rsp_queue", 32'(expq.size()), 32'd1);
          else begin
            e = expq.pop_front();
            chk({e.tag, "_err"}, {31'b0, lsu_rsp_err}, {31'b0, e.err});
            chk({e.tag, "_rdata"}, lsu_rsp_rdata, e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic send(input string tag, input logic rd, input logic [31:0] a, input logic [1:0] sz,
                      input logic us, input logic [31:0] wd, input logic mis,
                      input logic [31:0] xa, input logic [31:0] xwd, input logic [3:0] xm,
                      input logic [31:0] xrd);
    exp_t e;
    lsu_cmd_valid = 1'b1;
    lsu_cmd_read  = rd;
    lsu_cmd_addr  = a;
    lsu_cmd_size  = sz;
    lsu_cmd_usign = us;
    lsu_cmd_wdata = wd;
    e = '{tag, mis, xrd};
    expq.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lsu_cmd_ready) break;
    end
    chk({tag, "_acc"}, {31'b0, lsu_cmd_ready}, 32'd1);
    if (mis) chk({tag, "_memv"}, {31'b0, mem_icb_cmd_valid}, 32'd0);
    else begin
      chk({tag, "_memv"}, {31'b0, mem_icb_cmd_valid}, 32'd1);
      chk({tag, "_addr"}, mem_icb_cmd_addr, xa);
      chk({tag, "_wdata"}, mem_icb_cmd_wdata, xwd);
      chk({tag, "_wmask"}, {28'b0, mem_icb_cmd_wmask}, {28'b0, xm});
      chk({tag, "_rd"}, {31'b0, mem_icb_cmd_read}, {31'b0, rd});
    end
    @(posedge clk);
    #1;
    lsu_cmd_valid = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] sz, input logic us,
                    input logic mis, input logic [31:0] xa, input logic [31:0] xrd);
    send(tag, 1'b1, a, sz, us, 32'h0, mis, xa, 32'h0, 4'hF, xrd);
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                    input logic mis, input logic [31:0] xa, input logic [31:0] xwd, input logic [3:0] xm);
    send(tag, 1'b0, a, sz, 1'b0, wd, mis, xa, xwd, xm, 32'h0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (expq.size() == 0) break;
      @(negedge clk);
    end
    chk({tag, "_drain"}, 32'(expq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_icb_cmd_ready = 1'b1;
    lsu_cmd_valid = 1'b1;
    lsu_cmd_read  = 1'b1;
    lsu_cmd_addr  = 32'h200;
    lsu_cmd_size  = 2'd2;
    lsu_cmd_usign = 1'b0;
    lsu_cmd_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, lsu_rsp_valid}, 32'd0);
    chk("rst_mem_rsp_ready", {31'b0, mem_icb_rsp_ready}, 32'd0);
    chk("rst_cmd_ready", {31'b0, lsu_cmd_ready}, 32'd0);
    chk("rst_mem_cmd_valid", {31'b0, mem_icb_cmd_valid}, 32'd0);
    @(posedge clk);
    #1;
    lsu_cmd_valid = 1'b0;
    rst = 1'b0;
    rsp_mode = 1;
    @(posedge clk);
    #1;

    st("sb103", 32'h103, 2'd0, 32'h0000_00A5, 1'b0, 32'h100, 32'hA5A5_A5A5, 4'b1000);
    drain("sb");
    chk("mem_after_sb", mem[8'h40], 32'hA500_0000);

    ld("lb200",  32'h200, 2'd0, 1'b0, 1'b0, 32'h200, 32'hFFFF_FF80);
    ld("lbu200", 32'h200, 2'd0, 1'b1, 1'b0, 32'h200, 32'h0000_0080);
    ld("lh202",  32'h202, 2'd1, 1'b0, 1'b0, 32'h200, 32'hFFFF_8001);
    ld("lhu202", 32'h202, 2'd1, 1'b1, 1'b0, 32'h200, 32'h0000_8001);
    ld("lb201",  32'h201, 2'd0, 1'b0, 1'b0, 32'h200, 32'h0000_007F);
    ld("lbu203", 32'h203, 2'd0, 1'b1, 1'b0, 32'h200, 32'h0000_0080);
    ld("lw200",  32'h200, 2'd2, 1'b0, 1'b0, 32'h200, 32'h8001_7F80);
    drain("loads");

    ld("lw201",  32'h201, 2'd2, 1'b0, 1'b1, 32'h0, 32'h0);
    st("sh103",  32'h103, 2'd1, 32'h0000_BEEF, 1'b1, 32'h0, 32'h0, 4'h0);
    ld("lsz3",   32'h200, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0);
    drain("mis");
    chk("mem_after_mis", mem[8'h40], 32'hA500_0000);

    st("sh102",  32'h102, 2'd1, 32'h0000_1234, 1'b0, 32'h100, 32'h1234_1234, 4'b1100);
    ld("lw100",  32'h100, 2'd2, 1'b0, 1'b0, 32'h100, 32'h1234_0000);
    st("sw204",  32'h204, 2'd2, 32'hCAFE_F00D, 1'b0, 32'h204, 32'hCAFE_F00D, 4'hF);
    ld("lhu206", 32'h206, 2'd1, 1'b1, 1'b0, 32'h204, 32'h0000_CAFE);
    drain("mixed");

    rsp_mode = 0;
    ld("f1", 32'h200, 2'd2, 1'b0, 1'b0, 32'h200, 32'h8001_7F80);
    ld("f2", 32'h200, 2'd0, 1'b1, 1'b0, 32'h200, 32'h0000_0080);
    lsu_cmd_valid = 1'b1;
    lsu_cmd_read  = 1'b1;
    lsu_cmd_addr  = 32'h202;
    lsu_cmd_size  = 2'd1;
    lsu_cmd_usign = 1'b1;
    expq.push_back('{"f3", 1'b0, 32'h0000_8001});
    repeat (3) begin
      @(negedge clk);
      chk("full_cmd_ready", {31'b0, lsu_cmd_ready}, 32'd0);
      chk("full_mem_cmd_valid", {31'b0, mem_icb_cmd_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_mode = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lsu_cmd_ready) break;
    end
    chk("f3_acc", {31'b0, lsu_cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    lsu_cmd_valid = 1'b0;
    drain("full");

    rsp_mode = 2;
    ld("i1", 32'h200, 2'd2, 1'b0, 1'b0, 32'h200, 32'h8001_7F80);
    st("i2", 32'h202, 2'd2, 32'h0000_0011, 1'b1, 32'h0, 32'h0, 4'h0);
    ld("i3", 32'h200, 2'd1, 1'b0, 1'b0, 32'h200, 32'h0000_7F80);
    drain("inter");
    chk("mem_after_inter", mem[8'h80], 32'h8001_7F80);
    rsp_mode = 0;
    @(posedge clk);
    #1;

    ld("r1", 32'h200, 2'd2, 1'b0, 1'b0, 32'h200, 32'h8001_7F80);
    ld("r2", 32'h204, 2'd2, 1'b0, 1'b0, 32'h204, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    rst = 1'b1;
    lsu_cmd_valid = 1'b1;
    lsu_cmd_addr  = 32'h200;
    lsu_cmd_size  = 2'd2;
    expq.delete();
    @(negedge clk);
    chk("midrst_rsp_valid", {31'b0, lsu_rsp_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'b0, lsu_cmd_ready}, 32'd0);
    chk("midrst_mem_cmd_valid", {31'b0, mem_icb_cmd_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lsu_cmd_valid = 1'b0;
    rsp_mode = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("postrst_rsp_valid", {31'b0, lsu_rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    ld("post_rst_lw", 32'h200, 2'd2, 1'b0, 1'b0, 32'h200, 32'h8001_7F80);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
